digit_serial_adder: RTL and testbench
=====================================

# digit_serial_adder

Parametrised, multi-cycle two's-complement adder/subtractor that processes a WIDTH-bit operand pair DIGIT bits per clock, LSB digit first, through one registered carry. It is the sequential successor to the team's fixed 4-bit ripple adder. It trades latency for area: one DIGIT-bit ripple slice is reused WIDTH/DIGIT times. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0: a+b+cin; 1: a−b−cin.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of MSB (in sub mode, 1 = no borrow).
- ovf  output  1  signed overflow.

## Operation
- N = WIDTH/DIGIT digits. States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b_eff = sub ? ~b : b, and carry = cin ^ sub. Clear the digit counter. Go to RUN.
- RUN: each cycle, add digit k of a and b_eff plus the carry register. Shift the DIGIT-bit result into sum from the top, so sum is LSB-aligned after N shifts. Update carry and increment k. After digit N−1: cout = final carry; ovf = carry-into-MSB ^ carry-out-of-MSB; go to DONE.
- DONE: out_valid=1. sum, cout and ovf are stable. On out_ready, go to IDLE.
- in_ready is asserted only in IDLE. in_valid in RUN or DONE is ignored and is not queued.
- Inputs a, b, cin and sub are sampled only on the accept cycle. Later changes have no effect.
- Reset at any time, including mid-RUN or in DONE: state=IDLE, counter=0, carry=0, sum=0, cout=0, ovf=0, out_valid=0, in_ready=1 on the cycle after rst is sampled high. Any operation in flight is discarded.
- DIGIT=WIDTH (N=1) is legal and degenerates to a one-cycle RUN.

## Timing
- Accept at edge T. Digits are processed at edges T+1..T+N. out_valid is high after edge T+N, so latency is N cycles.
- Result is held indefinitely while out_ready=0.
- DONE→IDLE takes one edge. Minimum issue interval is N+2 cycles: accept, N digit cycles, one DONE cycle with out_ready=1.
- in_ready and out_valid are decoded from registered state, with no combinational path from inputs.
- Carry chain per cycle is DIGIT bits long, independent of WIDTH.

## Structure
- Shared package (dsa_pkg): the state enum (IDLE, RUN, DONE) and a counter-width function clog2(N).
- Sub-module digit_adder: a combinational DIGIT-bit ripple adder built from full-adder cells. Its ports are x, y, ci, s, co and c_msb, where c_msb is the carry into the top bit, needed for ovf.
- The top level holds the FSM, operand shift registers, result shift register, counter and carry flop.

## Test plan
(WIDTH=16, DIGIT=4 unless stated)
- 0x1234 + 0x1111, cin=0, sub=0 → sum=0x2345, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
- 0xFFFF + 0x0001 → sum=0x0000, cout=1, ovf=0. Also 0x7FFF + 0x0001 → sum=0x8000, cout=0, ovf=1.
- sub=1: 0x0005 − 0x0007, cin=0 → sum=0xFFFE, cout=0, ovf=0. Also 0x8000 − 0x0001 → sum=0x7FFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE, with in_valid=1 and new operands → result unchanged, in_ready=0, new operands ignored. Raise out_ready → IDLE next cycle, then new operands accepted.
- Assert rst in the second RUN cycle → next cycle out_valid=0, in_ready=1, sum=0. A following 0x00FF + 0x0001 gives 0x0100.
- WIDTH=8, DIGIT=8: 0x80 + 0x80 → sum=0x00, cout=1, ovf=1, latency 1. WIDTH=8, DIGIT=1: same result, latency 8.

Source files
------------

// File: rtl/dsa_pkg.sv
// Shared types and helpers for the digit-serial adder.
package dsa_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } dsa_state_e;

  // Counter width for n digits; never below one bit so N=1 still has a counter.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Operand/result handshake bundle between producer, adder and consumer.
interface digit_serial_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder from full-adder cells; also exposes the carry into the MSB.
module digit_adder #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] i_x,
  input  logic [DIGIT-1:0] i_y,
  input  logic             i_ci,
  output logic [DIGIT-1:0] o_s,
  output logic             o_co,
  output logic             o_c_msb
);
  logic [DIGIT:0] w_c;

  assign w_c[0] = i_ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign o_s[i]   = i_x[i] ^ i_y[i] ^ w_c[i];
    assign w_c[i+1] = (i_x[i] & i_y[i]) | (w_c[i] & (i_x[i] ^ i_y[i]));
  end

  assign o_co    = w_c[DIGIT];
  assign o_c_msb = w_c[DIGIT-1];
endmodule

// File: rtl/digit_serial_adder.sv
// Two's-complement add/sub of WIDTH-bit operands, DIGIT bits per cycle, LSB digit first.
module digit_serial_adder
  import dsa_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  digit_serial_adder_if.slave bus
);
  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = clog2(N);
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  dsa_state_e       r_state, w_next_state;
  logic [CntW-1:0]  r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic             r_cout, r_ovf;

  logic [DIGIT-1:0] w_s;
  logic             w_co, w_c_msb, w_last;
  logic [WIDTH-1:0] w_sum_nxt;

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit (
    .i_x     (r_a[DIGIT-1:0]),
    .i_y     (r_b[DIGIT-1:0]),
    .i_ci    (r_carry),
    .o_s     (w_s),
    .o_co    (w_co),
    .o_c_msb (w_c_msb)
  );

  assign w_last    = (r_cnt == LastCnt);
  // New digit enters at the top; after N shifts the result is LSB-aligned.
  assign w_sum_nxt = WIDTH'({w_s, r_sum} >> DIGIT);

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      StIdle:  if (bus.in_valid)  w_next_state = StRun;
      StRun:   if (w_last)        w_next_state = StDone;
      StDone:  if (bus.out_ready) w_next_state = StIdle;
      default:                    w_next_state = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.cin ^ bus.sub;
            r_cnt   <= '0;
          end
        end
        StRun: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_sum   <= w_sum_nxt;
          r_carry <= w_co;
          r_cnt   <= r_cnt + CntW'(1);
          if (w_last) begin
            r_cout <= w_co;
            r_ovf  <= w_c_msb ^ w_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == StIdle);
  assign bus.out_valid = (r_state == StDone);
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for three adder configurations (16/4, 8/8, 8/1) against an arithmetic reference model.
module tb_digit_serial_adder;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic        t_valid, t_cin, t_sub, t_ordy;
  logic [15:0] t_a, t_b;
  logic        o_valid, o_in_ready, o_cout, o_ovf;
  logic [15:0] o_sum;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  digit_serial_adder_if #(.WIDTH(16)) if16 ();
  digit_serial_adder_if #(.WIDTH(8))  if8a ();
  digit_serial_adder_if #(.WIDTH(8))  if8b ();

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_d16 (.clk(clk), .rst(rst), .bus(if16));
  digit_serial_adder #(.WIDTH(8),  .DIGIT(8)) u_d8a (.clk(clk), .rst(rst), .bus(if8a));
  digit_serial_adder #(.WIDTH(8),  .DIGIT(1)) u_d8b (.clk(clk), .rst(rst), .bus(if8b));

  assign if16.in_valid  = t_valid && (sel == 2'd0);
  assign if8a.in_valid  = t_valid && (sel == 2'd1);
  assign if8b.in_valid  = t_valid && (sel == 2'd2);
  assign if16.out_ready = t_ordy && (sel == 2'd0);
  assign if8a.out_ready = t_ordy && (sel == 2'd1);
  assign if8b.out_ready = t_ordy && (sel == 2'd2);
  assign if16.a = t_a;       assign if16.b = t_b;
  assign if8a.a = t_a[7:0];  assign if8a.b = t_b[7:0];
  assign if8b.a = t_a[7:0];  assign if8b.b = t_b[7:0];
  assign if16.cin = t_cin;   assign if16.sub = t_sub;
  assign if8a.cin = t_cin;   assign if8a.sub = t_sub;
  assign if8b.cin = t_cin;   assign if8b.sub = t_sub;

  assign o_valid    = (sel == 2'd0) ? if16.out_valid : (sel == 2'd1) ? if8a.out_valid
                                                                     : if8b.out_valid;
  assign o_in_ready = (sel == 2'd0) ? if16.in_ready : (sel == 2'd1) ? if8a.in_ready
                                                                    : if8b.in_ready;
  assign o_sum      = (sel == 2'd0) ? if16.sum : (sel == 2'd1) ? {8'h00, if8a.sum}
                                                               : {8'h00, if8b.sum};
  assign o_cout     = (sel == 2'd0) ? if16.cout : (sel == 2'd1) ? if8a.cout : if8b.cout;
  assign o_ovf      = (sel == 2'd0) ? if16.ovf : (sel == 2'd1) ? if8a.ovf : if8b.ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic model(input int w, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub,
                       output logic [15:0] s, output logic co, output logic ov);
    longint one, m, ua, ub, sa, sb, ur, sr, c;
    one = 1;
    m   = (one << w) - 1;
    ua  = longint'(a) & m;
    ub  = longint'(b) & m;
    c   = longint'(cin);
    sa  = (ua >= (one << (w - 1))) ? ua - (one << w) : ua;
    sb  = (ub >= (one << (w - 1))) ? ub - (one << w) : ub;
    ur  = sub ? ua - ub - c : ua + ub + c;
    sr  = sub ? sa - sb - c : sa + sb + c;
    s   = 16'(ur & m);
    co  = sub ? (ur >= 0) : (ur > m);
    ov  = (sr < -(one << (w - 1))) || (sr > (one << (w - 1)) - 1);
  endtask

  task automatic op(input logic [1:0] s, input logic [15:0] a, input logic [15:0] b,
                    input logic cin, input logic sub, input int hold, input string tag);
    int          w, n, cyc;
    logic [15:0] es;
    logic        ec, eo;
    w = (s == 2'd0) ? 16 : 8;
    n = (s == 2'd0) ? 4 : (s == 2'd1) ? 1 : 8;
    model(w, a, b, cin, sub, es, ec, eo);
    @(negedge clk);
    sel = s; t_a = a; t_b = b; t_cin = cin; t_sub = sub; t_valid = 1'b1; t_ordy = 1'b0;
    #1 chk({tag, ".in_ready_idle"}, 32'(o_in_ready), 32'd1);
    @(posedge clk);
    #1;
    t_valid = 1'b0;
    t_a = 16'($urandom); t_b = 16'($urandom);
    t_cin = 1'($urandom); t_sub = 1'($urandom);
    cyc = 0;
    while (o_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk({tag, ".latency"}, 32'(cyc), 32'(n));
    chk({tag, ".sum"}, 32'(o_sum), 32'(es));
    chk({tag, ".cout"}, 32'(o_cout), 32'(ec));
    chk({tag, ".ovf"}, 32'(o_ovf), 32'(eo));
    for (int i = 0; i < hold; i++) begin
      t_valid = 1'b1;
      t_a = 16'($urandom); t_b = 16'($urandom);
      @(posedge clk);
      #1;
      chk({tag, ".hold_in_ready"}, 32'(o_in_ready), 32'd0);
      chk({tag, ".hold_valid"}, 32'(o_valid), 32'd1);
      chk({tag, ".hold_sum"}, 32'(o_sum), 32'(es));
    end
    t_valid = 1'b0;
    t_ordy  = 1'b1;
    @(posedge clk);
    #1;
    t_ordy = 1'b0;
    chk({tag, ".rel_valid"}, 32'(o_valid), 32'd0);
    chk({tag, ".rel_in_ready"}, 32'(o_in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; sel = 2'd0;
    t_valid = 1'b0; t_a = '0; t_b = '0; t_cin = 1'b0; t_sub = 1'b0; t_ordy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      chk("reset.in_ready", 32'(o_in_ready), 32'd1);
      chk("reset.out_valid", 32'(o_valid), 32'd0);
      chk("reset.sum", 32'(o_sum), 32'd0);
      chk("reset.cout", 32'(o_cout), 32'd0);
      chk("reset.ovf", 32'(o_ovf), 32'd0);
    end
    rst = 1'b0;

    op(2'd0, 16'h1234, 16'h1111, 1'b0, 1'b0, 0, "add_basic");
    op(2'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, "add_wrap");
    op(2'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, "add_ovf");
    op(2'd0, 16'h0005, 16'h0007, 1'b0, 1'b1, 0, "sub_neg");
    op(2'd0, 16'h8000, 16'h0001, 1'b0, 1'b1, 0, "sub_ovf");
    op(2'd0, 16'h0F0F, 16'h0101, 1'b1, 1'b1, 0, "sub_borrow_in");
    op(2'd0, 16'hABCD, 16'h1357, 1'b1, 1'b0, 3, "backpressure");
    op(2'd0, 16'h2222, 16'h3333, 1'b0, 1'b0, 0, "after_bp");

    // Reset lands in the second digit cycle of a 16-bit operation.
    @(negedge clk);
    sel = 2'd0; t_a = 16'hFFFF; t_b = 16'h0000; t_cin = 1'b0; t_sub = 1'b0; t_valid = 1'b1;
    @(posedge clk);
    #1 t_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst.out_valid", 32'(o_valid), 32'd0);
    chk("midrst.in_ready", 32'(o_in_ready), 32'd1);
    chk("midrst.sum", 32'(o_sum), 32'd0);
    chk("midrst.cout", 32'(o_cout), 32'd0);
    chk("midrst.ovf", 32'(o_ovf), 32'd0);
    op(2'd0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 0, "post_rst");

    op(2'd1, 16'h0080, 16'h0080, 1'b0, 1'b0, 0, "w8d8_80p80");
    op(2'd2, 16'h0080, 16'h0080, 1'b0, 1'b0, 0, "w8d1_80p80");
    op(2'd1, 16'h007F, 16'h00FF, 1'b0, 1'b1, 1, "w8d8_sub");
    op(2'd2, 16'h0000, 16'h0000, 1'b1, 1'b1, 2, "w8d1_sub_bin");

    for (int i = 0; i < 24; i++) begin
      op(2'(i % 3), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
         int'($urandom_range(0, 2)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
